// File: rtl/tiny_proc_pkg.sv
// Shared definitions for the tiny 4-bit processor: run-controller state encodings,
// PC width and default phase count.
package tiny_proc_pkg;

  localparam int PC_W       = 4;
  localparam int PHASES_DEF = 5;

  typedef enum logic [2:0] {
    ST_HALT      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_EXEC      = 3'd2,
    ST_CHECK     = 3'd3,
    ST_BREAK     = 3'd4
  } run_state_t;

  typedef struct packed {
    logic core_en;
    logic instr_done;
    logic halted;
    logic at_break;
  } ctrl_out_t;

  // Counter width for a modulus of n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tiny_proc_run_ctrl_prescaler.sv
// Free-running tick divider: counts while enabled and pulses tc combinationally
// on the TICK_DIV-1 count, then wraps to zero.
module tick_prescaler
  import tiny_proc_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int            TW     = cnt_width(TICK_DIV);
  localparam logic [TW-1:0] TC_VAL = TW'(TICK_DIV - 1);

  logic [TW-1:0] cnt;

  assign tc = en && (cnt == TC_VAL);

  always_ff @(posedge clock) begin
    if (!reset_n)  cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= tc ? '0 : cnt + TW'(1);
  end

endmodule

// File: rtl/tiny_proc_run_ctrl.sv
// Execution controller for the tiny processor core: gates the per-phase core enable
// for run / halt / single-step / PC breakpoint / soft reset.
module tiny_proc_run_ctrl
  import tiny_proc_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int PHASES   = PHASES_DEF,
  parameter int CNT_W    = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run_i,
  input  logic             step_i,
  input  logic             sreset_i,
  input  logic             bp_en_i,
  input  logic [PC_W-1:0]  bp_addr_i,
  input  logic [PC_W-1:0]  core_pc_i,
  output logic             core_en_o,
  output logic             core_reset_p_o,
  output logic             instr_done_o,
  output logic             halted_o,
  output logic             at_break_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic [2:0]       state_o
);

  localparam int              PH_W    = cnt_width(PHASES);
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(PHASES - 1);

  run_state_t      state, state_nxt;
  logic [PH_W-1:0] phase, phase_nxt;
  logic            single, single_nxt;
  logic            tick_tc;
  logic            bp_hit;
  ctrl_out_t       out_q, out_nxt;
  logic            core_reset_q;
  logic [CNT_W-1:0] retire_cnt;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (sreset_i || (state != ST_WAIT_TICK)),
    .en      (state == ST_WAIT_TICK),
    .tc      (tick_tc)
  );

  assign bp_hit = bp_en_i && (core_pc_i == bp_addr_i);

  // State register; outputs are registered from the next-state values so they
  // line up with the state they describe.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= ST_HALT;
      phase        <= '0;
      single       <= 1'b0;
      retire_cnt   <= '0;
      core_reset_q <= 1'b1;
      out_q        <= '{core_en: 1'b0, instr_done: 1'b0, halted: 1'b1, at_break: 1'b0};
    end else begin
      state        <= state_nxt;
      phase        <= phase_nxt;
      single       <= single_nxt;
      core_reset_q <= sreset_i;
      out_q        <= out_nxt;
      if (sreset_i)                retire_cnt <= '0;
      else if (out_nxt.instr_done) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  // Next-state logic; soft reset overrides everything, including a partial instruction.
  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    single_nxt = single;
    if (sreset_i) begin
      state_nxt  = ST_HALT;
      phase_nxt  = '0;
      single_nxt = 1'b0;
    end else begin
      case (state)
        ST_HALT: begin
          if (step_i) begin
            state_nxt  = ST_EXEC;
            phase_nxt  = '0;
            single_nxt = 1'b1;
          end else if (run_i) begin
            state_nxt  = ST_WAIT_TICK;
          end
        end
        ST_WAIT_TICK: begin
          if (!run_i) begin
            state_nxt = ST_HALT;
          end else if (tick_tc) begin
            state_nxt  = ST_EXEC;
            phase_nxt  = '0;
            single_nxt = 1'b0;
          end
        end
        ST_EXEC: begin
          if (phase == LAST_PH) begin
            state_nxt = ST_CHECK;
            phase_nxt = '0;
          end else begin
            phase_nxt = phase + PH_W'(1);
          end
        end
        ST_CHECK: begin
          // A single step never stops at a breakpoint, so stepping off one works.
          if (single)      state_nxt = ST_HALT;
          else if (bp_hit) state_nxt = ST_BREAK;
          else if (run_i)  state_nxt = ST_WAIT_TICK;
          else             state_nxt = ST_HALT;
        end
        ST_BREAK: begin
          if (step_i) begin
            state_nxt  = ST_EXEC;
            phase_nxt  = '0;
            single_nxt = 1'b1;
          end else if (!run_i) begin
            state_nxt  = ST_HALT;
          end
        end
        default: begin
          state_nxt  = ST_HALT;
          phase_nxt  = '0;
          single_nxt = 1'b0;
        end
      endcase
    end
  end

  // Output decode from next state.
  always_comb begin
    out_nxt            = '0;
    out_nxt.core_en    = (state_nxt == ST_EXEC);
    out_nxt.instr_done = (state_nxt == ST_EXEC) && (phase_nxt == LAST_PH);
    out_nxt.halted     = (state_nxt == ST_HALT) || (state_nxt == ST_BREAK);
    out_nxt.at_break   = (state_nxt == ST_BREAK);
  end

  assign core_en_o      = out_q.core_en;
  assign instr_done_o   = out_q.instr_done;
  assign halted_o       = out_q.halted;
  assign at_break_o     = out_q.at_break;
  assign core_reset_p_o = core_reset_q;
  assign retire_cnt_o   = retire_cnt;
  assign state_o        = state;

endmodule

// File: tb/tb_tiny_proc_run_ctrl.sv
// Directed bench for tiny_proc_run_ctrl with a PC-incrementer core model.
module tb_tiny_proc_run_ctrl;

  logic       clock = 1'b0;
  logic       reset_n, run_i, step_i, sreset_i, bp_en_i;
  logic [3:0] bp_addr_i, pc;
  logic       core_en_o, core_reset_p_o, instr_done_o, halted_o, at_break_o;
  logic [7:0] retire_cnt_o;
  logic [2:0] state_o;

  int checks = 0;
  int passes = 0;

  tiny_proc_run_ctrl #(.TICK_DIV(4), .PHASES(5), .CNT_W(8)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .run_i          (run_i),
    .step_i         (step_i),
    .sreset_i       (sreset_i),
    .bp_en_i        (bp_en_i),
    .bp_addr_i      (bp_addr_i),
    .core_pc_i      (pc),
    .core_en_o      (core_en_o),
    .core_reset_p_o (core_reset_p_o),
    .instr_done_o   (instr_done_o),
    .halted_o       (halted_o),
    .at_break_o     (at_break_o),
    .retire_cnt_o   (retire_cnt_o),
    .state_o        (state_o)
  );

  always #5 clock = ~clock;

  // Core model: PC advances on the last enabled phase of each instruction.
  always @(posedge clock) begin
    if (core_reset_p_o)                  pc <= 4'd0;
    else if (core_en_o && instr_done_o)  pc <= pc + 4'd1;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_sreset;
    sreset_i = 1'b1;
    tick;
    sreset_i = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; run_i = 1'b0; step_i = 1'b0; sreset_i = 1'b0;
    bp_en_i = 1'b0; bp_addr_i = 4'd0;
    repeat (3) tick;
    checks++; if (halted_o !== 1'b1) $display("FAIL reset_halted: got %b want 1", halted_o); else passes++;
    checks++; if (core_en_o !== 1'b0) $display("FAIL reset_core_en: got %b want 0", core_en_o); else passes++;
    checks++; if (retire_cnt_o !== 8'd0) $display("FAIL reset_retire: got %0d want 0", retire_cnt_o); else passes++;
    checks++; if (core_reset_p_o !== 1'b1) $display("FAIL reset_core_reset: got %b want 1", core_reset_p_o); else passes++;
    checks++; if (state_o !== 3'd0) $display("FAIL reset_state: got %0d want 0", state_o); else passes++;
    checks++; if (at_break_o !== 1'b0) $display("FAIL reset_at_break: got %b want 0", at_break_o); else passes++;
    reset_n = 1'b1;
    tick;
    checks++; if (core_reset_p_o !== 1'b0) $display("FAIL reset_release: got %b want 0", core_reset_p_o); else passes++;
  endtask

  task automatic test_step;
    int   en_n, done_n, done_at;
    logic h5, h6;
    en_n = 0; done_n = 0; done_at = -1; h5 = 1'bx; h6 = 1'bx;
    step_i = 1'b1;
    tick;
    step_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (core_en_o) en_n++;
      if (instr_done_o) begin done_n++; done_at = i; end
      if (i == 5) h5 = halted_o;
      if (i == 6) h6 = halted_o;
      tick;
    end
    checks++; if (en_n != 5) $display("FAIL step_en_clocks: got %0d want 5", en_n); else passes++;
    checks++; if (done_n != 1) $display("FAIL step_done_count: got %0d want 1", done_n); else passes++;
    checks++; if (done_at != 4) $display("FAIL step_done_latency: got %0d want 4", done_at); else passes++;
    checks++; if (h5 !== 1'b0 || h6 !== 1'b1) $display("FAIL step_halt_latency: got %b%b want 01", h5, h6); else passes++;
    checks++; if (retire_cnt_o !== 8'd1) $display("FAIL step_retire: got %0d want 1", retire_cnt_o); else passes++;
    checks++; if (state_o !== 3'd0) $display("FAIL step_state: got %0d want 0", state_o); else passes++;
    checks++; if (pc !== 4'd1) $display("FAIL step_pc: got %0d want 1", pc); else passes++;
  endtask

  task automatic test_run;
    int done_idx[$];
    int d;
    pulse_sreset;
    run_i = 1'b1;
    tick;
    for (int i = 0; i < 40; i++) begin
      if (instr_done_o) done_idx.push_back(i);
      tick;
    end
    checks++; if (done_idx.size() != 4) $display("FAIL run_issue_count: got %0d want 4", done_idx.size()); else passes++;
    checks++;
    if (done_idx.size() != 4) $display("FAIL run_spacing: got %0d issues want 4", done_idx.size());
    else if (done_idx[0] != 8 || done_idx[1] != 18 || done_idx[2] != 28 || done_idx[3] != 38)
      $display("FAIL run_spacing: got %0d,%0d,%0d,%0d want 8,18,28,38", done_idx[0], done_idx[1], done_idx[2], done_idx[3]);
    else passes++;
    checks++; if (retire_cnt_o !== 8'd4) $display("FAIL run_retire: got %0d want 4", retire_cnt_o); else passes++;
    for (int i = 0; i < 20 && core_en_o !== 1'b1; i++) tick;
    checks++; if (core_en_o !== 1'b1) $display("FAIL run_exec_timeout: got %b want 1", core_en_o); else passes++;
    tick;
    run_i = 1'b0;
    d = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (instr_done_o) d++;
    end
    checks++; if (d != 1) $display("FAIL run_drop_completes: got %0d want 1", d); else passes++;
    checks++; if (state_o !== 3'd0) $display("FAIL run_drop_state: got %0d want 0", state_o); else passes++;
    checks++; if (retire_cnt_o !== 8'd5) $display("FAIL run_drop_retire: got %0d want 5", retire_cnt_o); else passes++;
  endtask

  task automatic test_breakpoint;
    pulse_sreset;
    bp_en_i = 1'b1; bp_addr_i = 4'd3; run_i = 1'b1;
    for (int i = 0; i < 100 && at_break_o !== 1'b1; i++) tick;
    checks++; if (at_break_o !== 1'b1) $display("FAIL bp_reached: got %b want 1", at_break_o); else passes++;
    checks++; if (pc !== 4'd3) $display("FAIL bp_pc: got %0d want 3", pc); else passes++;
    checks++; if (retire_cnt_o !== 8'd3) $display("FAIL bp_retire: got %0d want 3", retire_cnt_o); else passes++;
    checks++; if (halted_o !== 1'b1) $display("FAIL bp_halted: got %b want 1", halted_o); else passes++;
    repeat (4) tick;
    checks++; if (state_o !== 3'd4) $display("FAIL bp_hold_with_run: got %0d want 4", state_o); else passes++;
    // Step off with the breakpoint moved onto the next PC: a step must not break.
    step_i = 1'b1; run_i = 1'b0; bp_addr_i = 4'd4;
    tick;
    step_i = 1'b0;
    checks++; if (core_en_o !== 1'b1) $display("FAIL bp_step_start: got %b want 1", core_en_o); else passes++;
    repeat (6) tick;
    checks++; if (state_o !== 3'd0) $display("FAIL bp_step_state: got %0d want 0", state_o); else passes++;
    checks++; if (at_break_o !== 1'b0) $display("FAIL bp_step_at_break: got %b want 0", at_break_o); else passes++;
    checks++; if (pc !== 4'd4) $display("FAIL bp_step_pc: got %0d want 4", pc); else passes++;
    run_i = 1'b1;
    for (int i = 0; i < 30 && instr_done_o !== 1'b1; i++) tick;
    tick;
    checks++; if (pc !== 4'd5) $display("FAIL bp_resume_pc: got %0d want 5", pc); else passes++;
    run_i = 1'b0; bp_en_i = 1'b0;
    repeat (3) tick;
    checks++; if (state_o !== 3'd0) $display("FAIL bp_final_halt: got %0d want 0", state_o); else passes++;
  endtask

  task automatic test_sreset;
    int d;
    step_i = 1'b1;
    tick;
    step_i = 1'b0;
    repeat (2) tick;
    sreset_i = 1'b1;
    tick;
    sreset_i = 1'b0;
    checks++; if (core_reset_p_o !== 1'b1) $display("FAIL sreset_pulse: got %b want 1", core_reset_p_o); else passes++;
    checks++; if (core_en_o !== 1'b0) $display("FAIL sreset_core_en: got %b want 0", core_en_o); else passes++;
    checks++; if (retire_cnt_o !== 8'd0) $display("FAIL sreset_retire: got %0d want 0", retire_cnt_o); else passes++;
    checks++; if (state_o !== 3'd0 || halted_o !== 1'b1) $display("FAIL sreset_state: got %0d/%b want 0/1", state_o, halted_o); else passes++;
    tick;
    checks++; if (core_reset_p_o !== 1'b0) $display("FAIL sreset_one_clock: got %b want 0", core_reset_p_o); else passes++;
    d = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (instr_done_o) d++;
    end
    checks++; if (d != 0) $display("FAIL sreset_discard: got %0d want 0", d); else passes++;
    checks++; if (pc !== 4'd0) $display("FAIL sreset_pc: got %0d want 0", pc); else passes++;
  endtask

  task automatic test_wrap;
    int d;
    d = 0;
    run_i = 1'b1;
    for (int i = 0; i < 4000 && d < 255; i++) begin
      tick;
      if (instr_done_o) d++;
    end
    run_i = 1'b0;
    checks++; if (d != 255) $display("FAIL wrap_timeout: got %0d want 255", d); else passes++;
    checks++; if (retire_cnt_o !== 8'd255) $display("FAIL wrap_255: got %0d want 255", retire_cnt_o); else passes++;
    repeat (3) tick;
    checks++; if (state_o !== 3'd0) $display("FAIL wrap_halt: got %0d want 0", state_o); else passes++;
    step_i = 1'b1;
    tick;
    step_i = 1'b0;
    repeat (7) tick;
    checks++; if (retire_cnt_o !== 8'd0) $display("FAIL wrap_zero: got %0d want 0", retire_cnt_o); else passes++;
  endtask

  task automatic test_back_to_back;
    step_i = 1'b1; run_i = 1'b1;
    tick;
    step_i = 1'b0;
    checks++; if (state_o !== 3'd2) $display("FAIL b2b_exec: got %0d want 2", state_o); else passes++;
    repeat (5) tick;
    checks++; if (state_o !== 3'd3) $display("FAIL b2b_check: got %0d want 3", state_o); else passes++;
    tick;
    checks++; if (state_o !== 3'd0) $display("FAIL b2b_halt_first: got %0d want 0", state_o); else passes++;
    tick;
    checks++; if (state_o !== 3'd1) $display("FAIL b2b_wait_after: got %0d want 1", state_o); else passes++;
    run_i = 1'b0;
    tick;
    checks++; if (state_o !== 3'd0) $display("FAIL b2b_run_drop: got %0d want 0", state_o); else passes++;
  endtask

  initial begin
    test_reset;
    test_step;
    test_run;
    test_breakpoint;
    test_sreset;
    test_wrap;
    test_back_to_back;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
